// File: rtl/present_dec_serial_pkg.sv
// Shared FSM states, inverse bit-permutation table and sizing constants for present_dec_serial.
// Macro PRESENT_DEC_KEYPREP_EN adds the KPREP state (on-chip forward key preparation).
package present_dec_serial_pkg;

  localparam int ROUND_CYCLES = 18;
  localparam int KEY_W        = 80;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
`ifdef PRESENT_DEC_KEYPREP_EN
    KPREP  = 3'd6,
`endif
    WHITEN = 3'd1,
    PLAY   = 3'd2,
    SBOX   = 3'd3,
    KEYX   = 3'd4,
    DONE   = 3'd5
  } state_e;

  // Output bit i of the inverse pLayer takes input bit PLAYER_INV[i] = 16*i mod 63 (bit 63 fixed).
  localparam logic [5:0] PLAYER_INV [64] = '{
    6'd0,  6'd16, 6'd32, 6'd48, 6'd1,  6'd17, 6'd33, 6'd49,
    6'd2,  6'd18, 6'd34, 6'd50, 6'd3,  6'd19, 6'd35, 6'd51,
    6'd4,  6'd20, 6'd36, 6'd52, 6'd5,  6'd21, 6'd37, 6'd53,
    6'd6,  6'd22, 6'd38, 6'd54, 6'd7,  6'd23, 6'd39, 6'd55,
    6'd8,  6'd24, 6'd40, 6'd56, 6'd9,  6'd25, 6'd41, 6'd57,
    6'd10, 6'd26, 6'd42, 6'd58, 6'd11, 6'd27, 6'd43, 6'd59,
    6'd12, 6'd28, 6'd44, 6'd60, 6'd13, 6'd29, 6'd45, 6'd61,
    6'd14, 6'd30, 6'd46, 6'd62, 6'd15, 6'd31, 6'd47, 6'd63
  };

endpackage

// File: rtl/present_dec_serial_sbox_inv.sv
// 4-bit PRESENT S-box lookups: inverse (always) and forward (only with PRESENT_DEC_KEYPREP_EN).
module sbox_inv (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Inverse PRESENT S-box table
  always_comb begin
    dout = 4'h0;
    case (din)
      4'h0: dout = 4'h5;
      4'h1: dout = 4'hE;
      4'h2: dout = 4'hF;
      4'h3: dout = 4'h8;
      4'h4: dout = 4'hC;
      4'h5: dout = 4'h1;
      4'h6: dout = 4'h2;
      4'h7: dout = 4'hD;
      4'h8: dout = 4'hB;
      4'h9: dout = 4'h4;
      4'hA: dout = 4'h6;
      4'hB: dout = 4'h3;
      4'hC: dout = 4'h0;
      4'hD: dout = 4'h7;
      4'hE: dout = 4'h9;
      4'hF: dout = 4'hA;
      default: dout = 4'h0;
    endcase
  end

endmodule

`ifdef PRESENT_DEC_KEYPREP_EN
module sbox (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Forward PRESENT S-box table
  always_comb begin
    dout = 4'h0;
    case (din)
      4'h0: dout = 4'hC;
      4'h1: dout = 4'h5;
      4'h2: dout = 4'h6;
      4'h3: dout = 4'hB;
      4'h4: dout = 4'h9;
      4'h5: dout = 4'h0;
      4'h6: dout = 4'hA;
      4'h7: dout = 4'hD;
      4'h8: dout = 4'h3;
      4'h9: dout = 4'hE;
      4'hA: dout = 4'hF;
      4'hB: dout = 4'h8;
      4'hC: dout = 4'h4;
      4'hD: dout = 4'h7;
      4'hE: dout = 4'h1;
      4'hF: dout = 4'h2;
      default: dout = 4'h0;
    endcase
  end

endmodule
`endif

// File: rtl/present_dec_serial.sv
// Serial PRESENT-80 decryptor: one shared inverse S-box, 18 clock edges per round.
// Macro PRESENT_DEC_KEYPREP_EN: key port takes the user key and KPREP derives the final round key.
module present_dec_serial
  import present_dec_serial_pkg::*;
#(
  parameter int ROUNDS = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      ciphertext,
  input  logic [KEY_W-1:0] key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      plaintext,
  output logic             busy
);

  localparam logic [3:0] NIB_LAST = 4'(ROUND_CYCLES - 3);
  localparam logic [4:0] RND_LAST = 5'(ROUNDS);

  state_e           state_r;
  logic [63:0]      data_r;
  logic [KEY_W-1:0] key_r;
  logic [4:0]       rnd_r;
  logic [3:0]       nib_r;
  logic [63:0]      plaintext_r;
  logic             out_valid_r;

  logic [3:0]       sbox_in_s;
  logic [3:0]       sbox_out_s;
  logic [63:0]      play_s;
  logic [KEY_W-1:0] key_mix_s;
  logic [KEY_W-1:0] key_inv_s;

  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign out_valid = out_valid_r;
  assign plaintext = plaintext_r;

  // Shared S-box serves the key nibble only in KEYX, otherwise the current data nibble
  always_comb begin
    sbox_in_s = 4'h0;
    if (state_r == KEYX) sbox_in_s = key_r[79:76];
    else                 sbox_in_s = data_r[{nib_r, 2'b00} +: 4];
  end

  sbox_inv u_sbox_inv (.din(sbox_in_s), .dout(sbox_out_s));

  // Inverse bit permutation
  always_comb begin
    play_s = '0;
    for (int i = 0; i < 64; i++) play_s[i] = data_r[PLAYER_INV[i]];
  end

  // Undo one forward key update: strip counter, inverse S-box, rotate right by 61
  always_comb begin
    key_mix_s = {sbox_out_s, key_r[75:20], key_r[19:15] ^ rnd_r, key_r[14:0]};
    key_inv_s = {key_mix_s[60:0], key_mix_s[79:61]};
  end

`ifdef PRESENT_DEC_KEYPREP_EN
  logic [KEY_W-1:0] key_rot_s;
  logic [KEY_W-1:0] key_fwd_s;
  logic [3:0]       fsbox_out_s;

  assign key_rot_s = {key_r[18:0], key_r[79:19]};

  sbox u_sbox (.din(key_rot_s[79:76]), .dout(fsbox_out_s));

  // One forward key-schedule step using round counter rnd_r
  always_comb begin
    key_fwd_s = {fsbox_out_s, key_rot_s[75:20], key_rot_s[19:15] ^ rnd_r, key_rot_s[14:0]};
  end
`endif

  // Control FSM with datapath and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      data_r      <= 64'h0;
      key_r       <= 80'h0;
      rnd_r       <= 5'd0;
      nib_r       <= 4'd0;
      plaintext_r <= 64'h0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            data_r <= ciphertext;
            key_r  <= key;
            nib_r  <= 4'd0;
`ifdef PRESENT_DEC_KEYPREP_EN
            rnd_r   <= 5'd1;
            state_r <= KPREP;
`else
            rnd_r   <= 5'd0;
            state_r <= WHITEN;
`endif
          end
        end
`ifdef PRESENT_DEC_KEYPREP_EN
        KPREP: begin
          key_r <= key_fwd_s;
          rnd_r <= rnd_r + 5'd1;
          if (rnd_r == RND_LAST) state_r <= WHITEN;
        end
`endif
        WHITEN: begin
          data_r  <= data_r ^ key_r[79:16];
          rnd_r   <= RND_LAST;
          state_r <= PLAY;
        end
        PLAY: begin
          data_r  <= play_s;
          nib_r   <= 4'd0;
          state_r <= SBOX;
        end
        SBOX: begin
          data_r[{nib_r, 2'b00} +: 4] <= sbox_out_s;
          nib_r <= nib_r + 4'd1;
          if (nib_r == NIB_LAST) state_r <= KEYX;
        end
        KEYX: begin
          key_r  <= key_inv_s;
          data_r <= data_r ^ key_inv_s[79:16];
          rnd_r  <= rnd_r - 5'd1;
          if (rnd_r > 5'd1) begin
            state_r <= PLAY;
          end else begin
            plaintext_r <= data_r ^ key_inv_s[79:16];
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present_dec_serial.sv
// Scoreboard bench for present_dec_serial: a behavioural PRESENT-80 encryptor supplies expected plaintexts.
module tb_present_dec_serial;

  localparam int ROUNDS = 31;
`ifdef PRESENT_DEC_KEYPREP_EN
  localparam int KP  = ROUNDS;
`else
  localparam int KP  = 0;
`endif
  localparam int LAT = ROUNDS * 18 + KP + 1;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b1;
  logic        in_valid   = 1'b0;
  logic        out_ready  = 1'b0;
  logic [63:0] ciphertext = 64'h0;
  logic [79:0] key        = 80'h0;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [63:0] plaintext;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q [$];
  int          acc_q [$];
  logic [3:0]  sb [16];
  logic [79:0] kv_key [4];
  logic [63:0] kv_ct [4];
  logic [63:0] kv_pt [4];

  present_dec_serial #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ciphertext(ciphertext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .plaintext(plaintext), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [79:0] ks_next(input logic [79:0] k, input logic [4:0] i);
    logic [79:0] t;
    t = {k[18:0], k[79:19]};
    t[79:76] = sb[t[79:76]];
    t[19:15] = t[19:15] ^ i;
    return t;
  endfunction

  function automatic logic [79:0] final_key(input logic [79:0] k0);
    logic [79:0] k;
    k = k0;
    for (int r = 1; r <= ROUNDS; r++) k = ks_next(k, 5'(r));
    return k;
  endfunction

  function automatic logic [63:0] enc(input logic [63:0] pt, input logic [79:0] k0);
    logic [63:0] s, p;
    logic [79:0] k;
    s = pt;
    k = k0;
    for (int r = 1; r <= ROUNDS; r++) begin
      s = s ^ k[79:16];
      for (int j = 0; j < 16; j++) s[4*j +: 4] = sb[s[4*j +: 4]];
      p = '0;
      for (int j = 0; j < 64; j++) p[(j == 63) ? 63 : (16 * j) % 63] = s[j];
      s = p;
      k = ks_next(k, 5'(r));
    end
    return s ^ k[79:16];
  endfunction

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Called at a negedge; offers one job and records its expectation
  task automatic drive_job(input logic [79:0] ukey, input logic [63:0] ct, input logic [63:0] pt);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("in_ready_wait", 80'(in_ready), 80'd1);
    in_valid   = 1'b1;
    ciphertext = ct;
`ifdef PRESENT_DEC_KEYPREP_EN
    key = ukey;
`else
    key = final_key(ukey);
`endif
    exp_q.push_back(pt);
    acc_q.push_back(cyc + 1);
    @(negedge clk);
    in_valid   = 1'b0;
    ciphertext = 64'h0;
    key        = 80'h0;
    check_eq("busy_after_accept", 80'(busy), 80'd1);
  endtask

  task automatic collect(input int hold);
    int n;
    int acc;
    int unstable;
    logic [63:0] want;
    n = 0;
    unstable = 0;
    while (!out_valid && n < LAT + 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("out_valid_seen", 80'(out_valid), 80'd1);
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard: output with no pending job");
      return;
    end
    want = exp_q.pop_front();
    acc  = acc_q.pop_front();
    check_eq("plaintext", 80'(plaintext), 80'(want));
    check_eq("latency", 80'(cyc - acc), 80'(LAT));
    check_eq("in_ready_in_done", 80'(in_ready), 80'd0);
    if (hold > 0) begin
      in_valid   = 1'b1;
      ciphertext = 64'hDEAD_BEEF_0BAD_F00D;
      key        = {80{1'b1}};
      repeat (hold) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || plaintext !== want || in_ready !== 1'b0) unstable++;
      end
      in_valid = 1'b0;
      check_eq("hold_unstable_cycles", 80'(unstable), 80'd0);
      check_eq("hold_plaintext", 80'(plaintext), 80'(want));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("out_valid_drop", 80'(out_valid), 80'd0);
    check_eq("in_ready_rise", 80'(in_ready), 80'd1);
    check_eq("busy_idle", 80'(busy), 80'd0);
  endtask

  initial begin
    logic [79:0] rk;
    logic [63:0] rp;
    sb = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    kv_key = '{80'h0, 80'h0, {80{1'b1}}, {80{1'b1}}};
    kv_pt  = '{64'h0, {64{1'b1}}, 64'h0, {64{1'b1}}};
    kv_ct  = '{64'h5579C1387B228445, 64'hA112FFC72F68417B,
               64'hE72C46C0F5945049, 64'h3333DCD3213210D2};

    #1 rst_n = 1'b0;
    #11;
    check_eq("rst_in_ready", 80'(in_ready), 80'd1);
    check_eq("rst_busy", 80'(busy), 80'd0);
    check_eq("rst_out_valid", 80'(out_valid), 80'd0);
    check_eq("rst_plaintext", 80'(plaintext), 80'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      drive_job(kv_key[i], kv_ct[i], kv_pt[i]);
      collect(0);
    end

    for (int i = 0; i < 4; i++) begin
      rk = {16'($urandom), $urandom, $urandom};
      rp = {$urandom, $urandom};
      drive_job(rk, enc(rp, rk), rp);
      collect(0);
    end

    // Stray in_valid while busy and a 20-cycle stall in DONE
    rk = {16'($urandom), $urandom, $urandom};
    rp = {$urandom, $urandom};
    drive_job(rk, enc(rp, rk), rp);
    repeat (50) @(negedge clk);
    in_valid   = 1'b1;
    ciphertext = 64'h0123_4567_89AB_CDEF;
    key        = 80'h1;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("in_ready_busy", 80'(in_ready), 80'd0);
    collect(20);

    // Reset during SBOX of round 10 discards the job
    rk = {16'($urandom), $urandom, $urandom};
    rp = {$urandom, $urandom};
    drive_job(rk, enc(rp, rk), rp);
    repeat (170 + KP) @(negedge clk);
    check_eq("busy_before_reset", 80'(busy), 80'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_in_ready", 80'(in_ready), 80'd1);
    check_eq("midrst_busy", 80'(busy), 80'd0);
    check_eq("midrst_out_valid", 80'(out_valid), 80'd0);
    check_eq("midrst_plaintext", 80'(plaintext), 80'd0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("no_output_after_reset", 80'(out_valid), 80'd0);

    drive_job(kv_key[1], kv_ct[1], kv_pt[1]);
    collect(0);
    rk = {16'($urandom), $urandom, $urandom};
    rp = {$urandom, $urandom};
    drive_job(rk, enc(rp, rk), rp);
    collect(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
